// File: rtl/lift_scan_ctrl.sv
// SCAN lift controller: latched request bitmap, timed per-floor travel, timed door open/close.
// Optional macro DOOR_SENSE_EN: door_obstruct during DOOR_CLOSE forces a full reopen.
module lift_scan_ctrl #(
    parameter int unsigned N_FLOORS     = 8,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned MOVE_CYCLES  = 4,
    parameter int unsigned DOOR_CYCLES  = 5,
    parameter int unsigned CLOSE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic                door_obstruct,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic                door_close,
    output logic                busy
);

    localparam int unsigned MAX_C_A = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned MAX_C   = (MAX_C_A > CLOSE_CYCLES) ? MAX_C_A : CLOSE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, DOOR_CLOSE} state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    move_cnt, move_d;
    logic [CNT_W-1:0]    door_cnt, door_d;
    logic [FLOOR_W-1:0]  floor_d;
    logic                dir_d;
    logic [N_FLOORS-1:0] set_mask, clr_mask, pending_d;
    logic                door_restart;
    logic [31:0]         req_idx;

    assign req_idx = 32'(req_floor);

`ifndef DOOR_SENSE_EN
    logic unused_obstruct;
    assign unused_obstruct = door_obstruct;
`endif

    function automatic logic any_above(input logic [N_FLOORS-1:0] p, input logic [31:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++)
            if (p[i] && (i > f)) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] p, input logic [31:0] f);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++)
            if (p[i] && (i < f)) r = 1'b1;
        return r;
    endfunction

    always_comb begin
        state_d      = state;
        floor_d      = current_floor;
        dir_d        = dir_up;
        move_d       = move_cnt;
        door_d       = door_cnt;
        set_mask     = '0;
        clr_mask     = '0;
        door_restart = 1'b0;

        if (req_valid && (req_idx < N_FLOORS)) begin
            if ((state == DOOR_OPEN) && (req_floor == current_floor))
                door_restart = 1'b1;
            else
                set_mask[req_floor] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (pending != '0) begin
                    if (pending[current_floor]) begin
                        state_d                 = DOOR_OPEN;
                        door_d                  = '0;
                        clr_mask[current_floor] = 1'b1;
                    end else if (dir_up ? any_above(pending, 32'(current_floor))
                                        : any_below(pending, 32'(current_floor))) begin
                        state_d = dir_up ? MOVE_UP : MOVE_DOWN;
                    end else begin
                        dir_d   = !dir_up;
                        state_d = dir_up ? MOVE_DOWN : MOVE_UP;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (move_cnt == CNT_W'(MOVE_CYCLES - 1)) begin
                    move_d  = '0;
                    floor_d = (state == MOVE_UP) ? current_floor + 1'b1 : current_floor - 1'b1;
                    // Arrival decision looks at the floor just reached, not the one left.
                    if (pending[floor_d]) begin
                        state_d           = DOOR_OPEN;
                        door_d            = '0;
                        clr_mask[floor_d] = 1'b1;
                    end else if ((state == MOVE_UP) ? any_above(pending, 32'(floor_d))
                                                    : any_below(pending, 32'(floor_d))) begin
                        state_d = state;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    move_d = move_cnt + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (door_restart) begin
                    door_d = '0;
                end else if (door_cnt == CNT_W'(DOOR_CYCLES - 1)) begin
                    state_d = DOOR_CLOSE;
                    door_d  = '0;
                end else begin
                    door_d = door_cnt + 1'b1;
                end
            end
            DOOR_CLOSE: begin
`ifdef DOOR_SENSE_EN
                if (door_obstruct) begin
                    state_d                 = DOOR_OPEN;
                    door_d                  = '0;
                    clr_mask[current_floor] = 1'b1;
                end else
`endif
                if (door_cnt == CNT_W'(CLOSE_CYCLES - 1)) begin
                    state_d = IDLE;
                    door_d  = '0;
                end else begin
                    door_d = door_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending | set_mask) & ~clr_mask;
    end

    // Outputs are registered from the next state so they stay Moore-aligned with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            move_cnt      <= '0;
            door_cnt      <= '0;
            motor_up      <= 1'b0;
            motor_down    <= 1'b0;
            door_open     <= 1'b0;
            door_close    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            current_floor <= floor_d;
            pending       <= pending_d;
            dir_up        <= dir_d;
            move_cnt      <= move_d;
            door_cnt      <= door_d;
            motor_up      <= (state_d == MOVE_UP);
            motor_down    <= (state_d == MOVE_DOWN);
            door_open     <= (state_d == DOOR_OPEN);
            door_close    <= (state_d == DOOR_CLOSE);
            busy          <= (state_d != IDLE) || (pending_d != '0);
        end
    end

endmodule
